// File: rtl/step_sequencer_ctrl.sv
// Run/pause/stop controller: a programmable prescaler paces a position counter that wraps at a limit.
// Build option: define SINGLE_STEP_EN to add step_req for single-stepping while PAUSED.
module step_sequencer_ctrl #(
   parameter int          PRESCALE_W     = 22,
   parameter int          POS_W          = 4,
   parameter int unsigned DEFAULT_PERIOD = 4194303,
   parameter int unsigned DEFAULT_LIMIT  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  stop,
   input  logic                  oneshot,
   input  logic                  cfg_load,
`ifdef SINGLE_STEP_EN
   input  logic                  step_req,
`endif
   input  logic [PRESCALE_W-1:0] period_in,
   input  logic [POS_W-1:0]      limit_in,
   output logic [POS_W-1:0]      position,
   output logic                  step_tick,
   output logic                  wrap,
   output logic                  done,
   output logic [1:0]            state,
   output logic                  cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] period_q, period_d;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [POS_W-1:0]      limit_q, limit_d;
   logic                  mode_q, mode_d;
   logic                  tick_q, tick_d;
   logic                  wrap_q, wrap_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;

   logic                  start_cmd;
   logic                  step_en;
   logic                  step_cmd;

   // stop > pause > start: lower-priority commands are dropped when a higher one is present
   assign start_cmd = start & ~pause & ~stop;
`ifdef SINGLE_STEP_EN
   assign step_cmd  = step_req & ~start & ~pause & ~stop;
`else
   assign step_cmd  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         period_q  <= PRESCALE_W'(DEFAULT_PERIOD);
         pos_q     <= '0;
         limit_q   <= POS_W'(DEFAULT_LIMIT);
         mode_q    <= 1'b0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         period_q  <= period_d;
         pos_q     <= pos_d;
         limit_q   <= limit_d;
         mode_q    <= mode_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      period_d  = period_q;
      pos_d     = pos_q;
      limit_d   = limit_q;
      mode_d    = mode_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      step_en   = 1'b0;

      if (cfg_load) begin
         if (state_q == ST_IDLE) begin
            period_d = period_in;
            limit_d  = limit_in;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_cmd) begin
               presc_d = '0;
               pos_d   = '0;
               mode_d  = oneshot;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               presc_d = '0;
               state_d = ST_IDLE;
            end else if (pause) begin
               state_d = ST_PAUSED;
            end else if (presc_q == period_q) begin
               step_en = 1'b1;
            end else begin
               presc_d = presc_q + PRESCALE_W'(1);
            end
         end
         ST_PAUSED: begin
            if (stop) begin
               presc_d = '0;
               state_d = ST_IDLE;
            end else if (start_cmd) begin
               state_d = ST_RUN;
            end else if (step_cmd) begin
               step_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Shared by the free-running step and the paused single step
      if (step_en) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if (pos_q == limit_q) begin
            pos_d  = '0;
            wrap_d = 1'b1;
            if (mode_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end else begin
            pos_d = pos_q + POS_W'(1);
         end
      end
   end

   always_comb begin
      position  = pos_q;
      step_tick = tick_q;
      wrap      = wrap_q;
      done      = done_q;
      state     = state_q;
      cfg_err   = cfg_err_q;
   end

endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// Self-checking bench for step_sequencer_ctrl: directed scenarios plus a random run against a reference model.
// Define SINGLE_STEP_EN for both files to exercise the step_req option.
module tb_step_sequencer_ctrl;

   localparam int PW   = 22;
   localparam int POSW = 4;
   localparam int DP   = 37;
   localparam int DL   = 5;

   logic            clk;
   logic            reset, start, pause, stop, oneshot, cfg_load;
   logic            step_req;
   logic [PW-1:0]   period_in;
   logic [POSW-1:0] limit_in;
   logic [POSW-1:0] position;
   logic            step_tick, wrap, done, cfg_err;
   logic [1:0]      state;

   int total = 0;
   int bad   = 0;

   step_sequencer_ctrl #(
      .PRESCALE_W(PW), .POS_W(POSW), .DEFAULT_PERIOD(DP), .DEFAULT_LIMIT(DL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .oneshot(oneshot), .cfg_load(cfg_load),
`ifdef SINGLE_STEP_EN
      .step_req(step_req),
`endif
      .period_in(period_in), .limit_in(limit_in), .position(position),
      .step_tick(step_tick), .wrap(wrap), .done(done), .state(state), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 run, 2 paused; counts are plain integers
   int          m_state, m_presc, m_pos, m_period, m_limit;
   bit          m_mode, m_tick, m_wrap, m_done, m_err;

   function automatic void take_step();
      m_presc = 0;
      m_tick  = 1;
      if (m_pos == m_limit) begin
         m_pos  = 0;
         m_wrap = 1;
         if (m_mode) begin
            m_done  = 1;
            m_state = 0;
         end
      end else begin
         m_pos = (m_pos + 1) % (1 << POSW);
      end
   endfunction

   function automatic void model_edge();
      m_tick = 0; m_wrap = 0; m_done = 0; m_err = 0;
      if (reset) begin
         m_state = 0; m_presc = 0; m_pos = 0; m_period = DP; m_limit = DL; m_mode = 0;
         return;
      end
      if (cfg_load) begin
         if (m_state == 0) begin
            m_period = int'(period_in);
            m_limit  = int'(limit_in);
         end else begin
            m_err = 1;
         end
      end
      if (m_state == 0) begin
         if (start && !pause && !stop) begin
            m_presc = 0; m_pos = 0; m_mode = oneshot; m_state = 1;
         end
      end else if (m_state == 1) begin
         if (stop) begin
            m_state = 0; m_presc = 0;
         end else if (pause) begin
            m_state = 2;
         end else if (m_presc == m_period) begin
            take_step();
         end else begin
            m_presc = m_presc + 1;
         end
      end else begin
         if (stop) begin
            m_state = 0; m_presc = 0;
         end else if (pause) begin
            m_state = 2;
         end else if (start) begin
            m_state = 1;
`ifdef SINGLE_STEP_EN
         end else if (step_req) begin
            take_step();
`endif
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; pause = 0; stop = 0; cfg_load = 0; step_req = 0; oneshot = 0;
   endtask

   task automatic load_cfg(input int per, input int lim);
      cfg_load = 1; period_in = PW'(per); limit_in = POSW'(lim);
      tick();
      cfg_load = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      period_in = '0; limit_in = '0;
      reset = 1;
      tick(); tick();
      total++;
      if (state !== 2'b00 || position !== 4'd0 || step_tick !== 1'b0 || wrap !== 1'b0 ||
          done !== 1'b0 || cfg_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got state=%b pos=%0d tick=%b wrap=%b done=%b err=%b, want all zero",
                  state, position, step_tick, wrap, done, cfg_err);
      end
      reset = 0;
      tick();
   endtask

   task automatic test_default_period();
      int n, maxpos;
      start = 1; tick(); start = 0;
      n = 0;
      while (n < 100 && step_tick !== 1'b1) begin tick(); n++; end
      total++;
      if (n != DP + 1 || position !== 4'd1) begin
         bad++;
         $display("FAIL default_period: first step after %0d cycles pos=%0d, want %0d cycles pos=1", n, position, DP + 1);
      end
      maxpos = 1; n = 0;
      while (n < 400 && wrap !== 1'b1) begin
         tick(); n++;
         if (int'(position) > maxpos) maxpos = int'(position);
      end
      total++;
      if (maxpos != DL || wrap !== 1'b1 || position !== 4'd0) begin
         bad++;
         $display("FAIL default_limit: max pos %0d wrap=%b pos=%0d, want max %0d then wrap to 0", maxpos, wrap, position, DL);
      end
      cfg_load = 1; period_in = PW'(2); tick(); cfg_load = 0;
      total++;
      if (cfg_err !== 1'b1) begin
         bad++; $display("FAIL cfg_err_run: got %b want 1", cfg_err);
      end
      while (position == 4'd0) tick();
      reset = 1; tick(); reset = 0;
      total++;
      if (state !== 2'b00 || position !== 4'd0 || step_tick !== 1'b0) begin
         bad++;
         $display("FAIL reset_midrun: got state=%b pos=%0d tick=%b, want 00/0/0", state, position, step_tick);
      end
   endtask

   task automatic test_continuous();
      int exp_pos;
      bit exp_tick;
      load_cfg(3, 2);
      start = 1; tick(); start = 0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         exp_tick = (k % 4 == 0);
         exp_pos  = (k / 4) % 3;
         total++;
         if (step_tick !== exp_tick || int'(position) != exp_pos || wrap !== (exp_tick && exp_pos == 0)) begin
            bad++;
            $display("FAIL continuous k=%0d: got tick=%b pos=%0d wrap=%b, want tick=%b pos=%0d wrap=%b",
                     k, step_tick, position, wrap, exp_tick, exp_pos, exp_tick && exp_pos == 0);
         end
      end
      stop = 1; tick(); stop = 0;
   endtask

   task automatic test_oneshot();
      bit exp_tick;
      load_cfg(1, 3);
      start = 1; oneshot = 1; tick(); start = 0; oneshot = 0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_tick = (k % 2 == 0) && k <= 8;
         total++;
         if (step_tick !== exp_tick || int'(position) != (k / 2) % 4 || done !== (k == 8) ||
             wrap !== (k == 8) || state !== ((k < 8) ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL oneshot k=%0d: got tick=%b pos=%0d done=%b wrap=%b state=%b",
                     k, step_tick, position, done, wrap, state);
         end
      end
   endtask

   task automatic test_pause_terminal();
      load_cfg(3, 2);
      start = 1; tick(); start = 0;
      tick(); tick(); tick();
      pause = 1; tick(); pause = 0;
      for (int k = 0; k < 10; k++) begin
         total++;
         if (state !== 2'b10 || position !== 4'd0 || step_tick !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold k=%0d: got state=%b pos=%0d tick=%b, want 10/0/0", k, state, position, step_tick);
         end
         tick();
      end
      start = 1; tick(); start = 0;
      total++;
      if (state !== 2'b01 || step_tick !== 1'b0) begin
         bad++; $display("FAIL resume: got state=%b tick=%b, want 01/0", state, step_tick);
      end
      tick();
      total++;
      if (step_tick !== 1'b1 || position !== 4'd1) begin
         bad++; $display("FAIL resume_step: got tick=%b pos=%0d, want 1/1", step_tick, position);
      end
      stop = 1; tick(); stop = 0;
   endtask

   task automatic test_priority_cfg();
      load_cfg(3, 4);
      start = 1; tick(); start = 0;
      for (int k = 0; k < 6; k++) tick();
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      total++;
      if (state !== 2'b00 || position !== 4'd1 || step_tick !== 1'b0) begin
         bad++; $display("FAIL start_stop_run: got state=%b pos=%0d tick=%b, want 00/1/0", state, position, step_tick);
      end
      start = 1; tick(); start = 0;
      cfg_load = 1; period_in = PW'(7); tick(); cfg_load = 0;
      total++;
      if (cfg_err !== 1'b1) begin
         bad++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err);
      end
      tick();
      total++;
      if (cfg_err !== 1'b0) begin
         bad++; $display("FAIL cfg_err_once: got %b want 0", cfg_err);
      end
      tick(); tick();
      total++;
      if (step_tick !== 1'b1 || position !== 4'd1) begin
         bad++; $display("FAIL period_kept: got tick=%b pos=%0d, want 1/1", step_tick, position);
      end
      pause = 1; start = 1; tick(); pause = 0; start = 0;
      total++;
      if (state !== 2'b10) begin
         bad++; $display("FAIL pause_over_start: got state=%b want 10", state);
      end
      cfg_load = 1; tick(); cfg_load = 0;
      total++;
      if (cfg_err !== 1'b1 || state !== 2'b10) begin
         bad++; $display("FAIL cfg_err_paused: got err=%b state=%b, want 1/10", cfg_err, state);
      end
      stop = 1; tick(); stop = 0;
      total++;
      if (state !== 2'b00) begin
         bad++; $display("FAIL stop_paused: got state=%b want 00", state);
      end
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      total++;
      if (state !== 2'b00) begin
         bad++; $display("FAIL start_stop_idle: got state=%b want 00", state);
      end
   endtask

   task automatic test_limit_zero();
      load_cfg(0, 0);
      start = 1; tick(); start = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         total++;
         if (step_tick !== 1'b1 || wrap !== 1'b1 || position !== 4'd0) begin
            bad++;
            $display("FAIL limit_zero k=%0d: got tick=%b wrap=%b pos=%0d, want 1/1/0", k, step_tick, wrap, position);
         end
      end
      stop = 1; tick(); stop = 0;
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_single_step();
      load_cfg(3, 2);
      start = 1; tick(); start = 0;
      for (int k = 0; k < 8; k++) tick();
      pause = 1; tick(); pause = 0;
      step_req = 1; tick(); step_req = 0;
      total++;
      if (position !== 4'd0 || wrap !== 1'b1 || step_tick !== 1'b1 || state !== 2'b10) begin
         bad++;
         $display("FAIL single_step: got pos=%0d wrap=%b tick=%b state=%b, want 0/1/1/10", position, wrap, step_tick, state);
      end
      start = 1; tick(); start = 0;
      step_req = 1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         step_req = 0;
         total++;
         if (step_tick !== (k == 4) || int'(position) != ((k == 4) ? 1 : 0)) begin
            bad++;
            $display("FAIL step_req_run k=%0d: got tick=%b pos=%0d", k, step_tick, position);
         end
      end
      stop = 1; tick(); stop = 0;
   endtask
`endif

   task automatic test_random();
      logic [9:0] got, exp;
      for (int k = 0; k < 3000; k++) begin
         reset    = ($urandom_range(399) == 0);
         start    = ($urandom_range(9) == 0);
         pause    = ($urandom_range(15) == 0);
         stop     = ($urandom_range(29) == 0);
         oneshot  = $urandom_range(1) == 1;
         cfg_load = ($urandom_range(11) == 0);
         step_req = ($urandom_range(5) == 0);
         period_in = PW'($urandom_range(4));
         limit_in  = POSW'($urandom_range(4));
         tick();
         got = {state, position, step_tick, wrap, done, cfg_err};
         exp = {2'(m_state), 4'(m_pos), m_tick, m_wrap, m_done, m_err};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL random k=%0d: got {state,pos,tick,wrap,done,err}=%b want %b", k, got, exp);
         end
      end
      reset = 0;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_default_period();
      test_continuous();
      test_oneshot();
      test_pause_terminal();
      test_priority_cfg();
      test_limit_zero();
`ifdef SINGLE_STEP_EN
      test_single_step();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
